guess_entry: RTL and testbench
==============================

GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 The block SHALL have parameter MAX_TRIES, default 8, giving the number of guesses allowed per game (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port digit_valid, input, 1 bit: one-cycle strobe marking digit_in valid (already debounced upstream).
REQ-005 The block SHALL have port digit_in, input, 4 bits: a BCD digit value.
REQ-006 The block SHALL have port clear, input, 1 bit: one-cycle strobe that discards the partial guess.
REQ-007 The block SHALL have port submit, input, 1 bit: one-cycle strobe requesting that the guess be checked.
REQ-008 The block SHALL have port new_game, input, 1 bit: one-cycle strobe that restarts the game from the WIN or LOSE state.
REQ-009 The block SHALL have port correct, input, 1 bit: the checker's full-match flag.
REQ-010 The block SHALL have port numCorrect, input, 4 bits: the checker's count of matching digits.
REQ-011 The block SHALL have port my_input, output, 16 bits: the assembled guess, four BCD digits, first-entered digit in [15:12].
REQ-012 The block SHALL have port send, output, 1 bit: the check request to the checker.
REQ-013 The block SHALL have port digit_count, output, 3 bits: the number of digits entered so far (0..4).
REQ-014 The block SHALL have port tries_left, output, 4 bits: the number of guesses remaining.
REQ-015 The block SHALL have port last_score, output, 4 bits: the numCorrect value latched from the most recent guess.
REQ-016 The block SHALL have ports win and lose, outputs, 1 bit each: game-over status flags.

Function
REQ-017 The state machine SHALL have states ENTRY, SEND, EVAL, WIN and LOSE.
REQ-018 In ENTRY, a digit_valid with digit_in <= 9 and digit_count < 4 SHALL shift the digit in: my_input <= {my_input[11:0], digit_in}, and digit_count SHALL increment.
REQ-019 digit_in values 10..15 SHALL be ignored; a digit arriving while digit_count == 4 SHALL be ignored.
REQ-020 In ENTRY, clear SHALL set my_input to 0 and digit_count to 0 in the next cycle.
REQ-021 If clear and digit_valid are asserted in the same cycle, clear SHALL win and the digit SHALL be discarded.
REQ-022 submit SHALL be accepted only in ENTRY with digit_count == 4 and no clear in the same cycle; an accepted submit SHALL move the state to SEND.
REQ-023 A submit arriving together with the fourth digit SHALL be ignored, because the acceptance test uses the pre-update digit_count.
REQ-024 In SEND, send SHALL be 1 for exactly one cycle with my_input stable; the state SHALL then move to EVAL.
REQ-025 In EVAL, which is the cycle after send, the block SHALL sample correct and numCorrect and latch numCorrect into last_score; the checker response latency is one cycle.
REQ-026 From EVAL with correct == 1, the next state SHALL be WIN, and tries_left SHALL be left unchanged.
REQ-027 From EVAL with correct == 0, tries_left SHALL decrement by 1; if the result is 0 the next state SHALL be LOSE, otherwise ENTRY with my_input = 0 and digit_count = 0.
REQ-028 tries_left SHALL never wrap below 0.
REQ-029 win SHALL be 1 exactly in the WIN state, and lose SHALL be 1 exactly in the LOSE state.
REQ-030 WIN and LOSE SHALL ignore digit_valid, clear and submit.
REQ-031 new_game in WIN or LOSE SHALL enter ENTRY with tries_left = MAX_TRIES, last_score = 0, my_input = 0 and digit_count = 0.
REQ-032 new_game in any other state SHALL be ignored.
REQ-033 In SEND and EVAL, all user strobes SHALL be ignored.

Reset
REQ-034 While rst_n is 0, asynchronously: state = ENTRY, my_input = 0, send = 0, digit_count = 0, tries_left = MAX_TRIES, last_score = 0, win = 0, lose = 0.
REQ-035 Reset asserted during SEND or EVAL SHALL abort the guess with no decrement of tries_left, and send SHALL drop immediately.
REQ-036 Release of reset SHALL be followed by normal ENTRY operation on the next rising edge of clk.

Structure
REQ-037 A shared package codebreak_pkg SHALL hold the state enumeration, DIGIT_W = 4, NUM_DIGITS = 4 and BCD_MAX = 9.
REQ-038 One sub-module guess_shift_reg SHALL hold the 4-digit shift register and digit counter, with shift, clear and full controls.
REQ-039 The FSM, try counter and score latch SHALL reside in guess_entry.
REQ-040 All outputs SHALL be registered.

Verification
REQ-041 Scenario: after reset, digits 1,2,3,4 then submit, checker returning correct = 1 and numCorrect = 4 -> my_input = 16'h1234, a single-cycle send, last_score = 4, win = 1, tries_left = 8.
REQ-042 Scenario: digits 1,2 then clear, then digits 5,6,7,8 -> my_input = 16'h5678 and digit_count = 4; a submit issued before the fourth digit produces no send.
REQ-043 Scenario: digit_in = 4'hA strobed -> my_input and digit_count unchanged; a fifth digit 9 after 1,2,3,4 -> my_input stays 16'h1234.
REQ-044 Scenario: MAX_TRIES = 2, two wrong guesses with numCorrect = 2 then 1 -> tries_left goes 2 -> 1 -> 0, lose = 1, last_score = 1; further digit strobes ignored; new_game -> tries_left = 2, lose = 0.
REQ-045 Scenario: clear and digit_valid (digit 7) in the same cycle with digit_count = 2 -> my_input = 0 and digit_count = 0.
REQ-046 Scenario: rst_n pulled low in the SEND cycle -> send drops immediately, tries_left = MAX_TRIES and state = ENTRY after release.

Source files
------------

// File: rtl/codebreak_pkg.sv
// Shared types and constants for the code-breaking game datapath.
// Pure declarations: no logic, no latency, no flow control.
package codebreak_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9;
  localparam int GUESS_W    = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W      = 3;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_SEND,
    ST_EVAL,
    ST_WIN,
    ST_LOSE
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/guess_shift_reg.sv
// Four-digit BCD shift register with a digit counter; shifts in at the low end.
// One-cycle update; shift is ignored while full, clear has priority over shift.
module guess_shift_reg
  import codebreak_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] digit,
  output logic [GUESS_W-1:0] data,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  assign full = (count == CNT_W'(NUM_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift && !full) begin
      data  <= {data[GUESS_W-DIGIT_W-1:0], digit};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Guess entry FSM: collects four BCD digits, issues a one-cycle send, then scores the reply.
// Checker reply is sampled the cycle after send; user strobes are dropped outside ENTRY/WIN/LOSE.
module guess_entry
  import codebreak_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               clear,
  input  logic               submit,
  input  logic               new_game,
  input  logic               correct,
  input  logic [3:0]         numCorrect,
  output logic [GUESS_W-1:0] my_input,
  output logic               send,
  output logic [CNT_W-1:0]   digit_count,
  output logic [3:0]         tries_left,
  output logic [3:0]         last_score,
  output logic               win,
  output logic               lose
);

  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

  state_t     state, state_nxt;
  logic       sr_shift, sr_clear, sr_full;
  logic [3:0] tries_nxt, score_nxt, tries_dec;

  guess_shift_reg u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (sr_shift),
    .clear (sr_clear),
    .digit (digit_in),
    .data  (my_input),
    .count (digit_count),
    .full  (sr_full)
  );

  // Saturating decrement so a stray wrong answer can never wrap the counter.
  assign tries_dec = (tries_left == 4'd0) ? 4'd0 : tries_left - 4'd1;

  always_comb begin
    state_nxt = state;
    sr_shift  = 1'b0;
    sr_clear  = 1'b0;
    tries_nxt = tries_left;
    score_nxt = last_score;
    case (state)
      ST_ENTRY: begin
        if (clear) begin
          sr_clear = 1'b1;
        end else begin
          sr_shift = digit_valid && is_bcd(digit_in) && !sr_full;
          // sr_full reflects the count before this cycle's digit lands.
          if (submit && sr_full) state_nxt = ST_SEND;
        end
      end
      ST_SEND: state_nxt = ST_EVAL;
      ST_EVAL: begin
        score_nxt = numCorrect;
        if (correct) begin
          state_nxt = ST_WIN;
        end else begin
          tries_nxt = tries_dec;
          if (tries_dec == 4'd0) begin
            state_nxt = ST_LOSE;
          end else begin
            state_nxt = ST_ENTRY;
            sr_clear  = 1'b1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (new_game) begin
          state_nxt = ST_ENTRY;
          tries_nxt = TRIES_INIT;
          score_nxt = 4'd0;
          sr_clear  = 1'b1;
        end
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ENTRY;
      tries_left <= TRIES_INIT;
      last_score <= 4'd0;
      send       <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tries_left <= tries_nxt;
      last_score <= score_nxt;
      send       <= (state_nxt == ST_SEND);
      win        <= (state_nxt == ST_WIN);
      lose       <= (state_nxt == ST_LOSE);
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: vector table, directed corner sequences, then random traffic vs a game model.
module tb_guess_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_valid = 1'b0, clear = 1'b0, submit = 1'b0, new_game = 1'b0, correct = 1'b0;
  logic [3:0] digit_in = 4'd0, num_correct = 4'd0;

  logic [15:0] mi_a, mi_b;
  logic [2:0]  cnt_a, cnt_b;
  logic [3:0]  tries_a, tries_b, score_a, score_b;
  logic        send_a, send_b, win_a, win_b, lose_a, lose_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  guess_entry dut_a (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(digit_in),
    .clear(clear), .submit(submit), .new_game(new_game), .correct(correct),
    .numCorrect(num_correct), .my_input(mi_a), .send(send_a), .digit_count(cnt_a),
    .tries_left(tries_a), .last_score(score_a), .win(win_a), .lose(lose_a)
  );

  guess_entry #(.MAX_TRIES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(digit_in),
    .clear(clear), .submit(submit), .new_game(new_game), .correct(correct),
    .numCorrect(num_correct), .my_input(mi_b), .send(send_b), .digit_count(cnt_b),
    .tries_left(tries_b), .last_score(score_b), .win(win_b), .lose(lose_b)
  );

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       clr, sub, ng, cor;
    logic [3:0] nc;
    logic [15:0] mi;
    logic [2:0]  cnt;
    logic        snd;
    logic [3:0]  tries, score;
    logic        win, lose;
  } vec_t;

  vec_t tbl[39];

  function automatic vec_t mk(input logic dv, input logic [3:0] d, input logic clr, sub, ng, cor,
                              input logic [3:0] nc, input logic [15:0] mi, input logic [2:0] cnt,
                              input logic snd, input logic [3:0] tries, score, input logic w, l);
    vec_t v;
    v.dv = dv; v.d = d; v.clr = clr; v.sub = sub; v.ng = ng; v.cor = cor; v.nc = nc;
    v.mi = mi; v.cnt = cnt; v.snd = snd; v.tries = tries; v.score = score; v.win = w; v.lose = l;
    return v;
  endfunction

  function automatic logic [29:0] obs(input int k);
    if (k == 0) return {mi_a, cnt_a, send_a, tries_a, score_a, win_a, lose_a};
    return {mi_b, cnt_b, send_b, tries_b, score_b, win_b, lose_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic clr, sub, ng, cor,
                       input logic [3:0] nc);
    digit_valid = dv; digit_in = d; clear = clr; submit = sub; new_game = ng;
    correct = cor; num_correct = nc;
  endtask

  task automatic step(input logic dv, input logic [3:0] d, input logic clr, sub, ng, cor,
                      input logic [3:0] nc);
    drive(dv, d, clr, sub, ng, cor, nc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Game-level reference model: digits kept as an array plus a count, phase as a small integer.
  int m_phase[2], m_tries[2], m_score[2], m_cnt[2];
  int m_dig[2][4];
  int m_max[2] = '{8, 2};

  task automatic m_reset(input int k);
    m_phase[k] = 0; m_tries[k] = m_max[k]; m_score[k] = 0; m_cnt[k] = 0;
  endtask

  task automatic m_step(input int k);
    bit accept;
    case (m_phase[k])
      0: begin
        accept = submit && !clear && (m_cnt[k] == 4);
        if (clear) m_cnt[k] = 0;
        else if (digit_valid && digit_in < 10 && m_cnt[k] < 4) begin
          m_dig[k][m_cnt[k]] = int'(digit_in);
          m_cnt[k]++;
        end
        if (accept) m_phase[k] = 1;
      end
      1: m_phase[k] = 2;
      2: begin
        m_score[k] = int'(num_correct);
        if (correct) m_phase[k] = 3;
        else begin
          if (m_tries[k] > 0) m_tries[k]--;
          if (m_tries[k] == 0) m_phase[k] = 4;
          else begin
            m_phase[k] = 0;
            m_cnt[k] = 0;
          end
        end
      end
      default: if (new_game) begin
        m_phase[k] = 0; m_tries[k] = m_max[k]; m_score[k] = 0; m_cnt[k] = 0;
      end
    endcase
  endtask

  function automatic logic [29:0] m_exp(input int k);
    int val = 0;
    for (int i = 0; i < m_cnt[k]; i++) val = val * 16 + m_dig[k][i];
    return {16'(val), 3'(m_cnt[k]), m_phase[k] == 1, 4'(m_tries[k]), 4'(m_score[k]),
            m_phase[k] == 3, m_phase[k] == 4};
  endfunction

  initial begin
    //             dv d   clr sub ng cor nc   my_input cnt snd tries score win lose
    tbl[0]  = mk(0, 0,   0, 0, 0, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[1]  = mk(1, 1,   0, 0, 0, 0, 0, 16'h0001, 1, 0, 8, 0, 0, 0);
    tbl[2]  = mk(1, 2,   0, 0, 0, 0, 0, 16'h0012, 2, 0, 8, 0, 0, 0);
    tbl[3]  = mk(1, 3,   0, 0, 0, 0, 0, 16'h0123, 3, 0, 8, 0, 0, 0);
    tbl[4]  = mk(1, 4'hA,0, 0, 0, 0, 0, 16'h0123, 3, 0, 8, 0, 0, 0);
    tbl[5]  = mk(1, 4,   0, 1, 0, 0, 0, 16'h1234, 4, 0, 8, 0, 0, 0);
    tbl[6]  = mk(0, 0,   0, 0, 0, 0, 0, 16'h1234, 4, 0, 8, 0, 0, 0);
    tbl[7]  = mk(1, 9,   0, 0, 0, 0, 0, 16'h1234, 4, 0, 8, 0, 0, 0);
    tbl[8]  = mk(0, 0,   0, 1, 0, 0, 0, 16'h1234, 4, 1, 8, 0, 0, 0);
    tbl[9]  = mk(1, 5,   0, 0, 1, 0, 7, 16'h1234, 4, 0, 8, 0, 0, 0);
    tbl[10] = mk(0, 0,   0, 0, 0, 1, 4, 16'h1234, 4, 0, 8, 4, 1, 0);
    tbl[11] = mk(1, 5,   1, 1, 0, 0, 0, 16'h1234, 4, 0, 8, 4, 1, 0);
    tbl[12] = mk(0, 0,   0, 0, 1, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[13] = mk(1, 1,   0, 0, 0, 0, 0, 16'h0001, 1, 0, 8, 0, 0, 0);
    tbl[14] = mk(1, 2,   0, 0, 0, 0, 0, 16'h0012, 2, 0, 8, 0, 0, 0);
    tbl[15] = mk(0, 0,   1, 0, 0, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[16] = mk(1, 5,   0, 0, 0, 0, 0, 16'h0005, 1, 0, 8, 0, 0, 0);
    tbl[17] = mk(1, 6,   0, 0, 0, 0, 0, 16'h0056, 2, 0, 8, 0, 0, 0);
    tbl[18] = mk(1, 7,   0, 0, 0, 0, 0, 16'h0567, 3, 0, 8, 0, 0, 0);
    tbl[19] = mk(0, 0,   0, 1, 0, 0, 0, 16'h0567, 3, 0, 8, 0, 0, 0);
    tbl[20] = mk(0, 0,   0, 0, 0, 0, 0, 16'h0567, 3, 0, 8, 0, 0, 0);
    tbl[21] = mk(1, 8,   0, 0, 0, 0, 0, 16'h5678, 4, 0, 8, 0, 0, 0);
    tbl[22] = mk(0, 0,   1, 0, 0, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[23] = mk(1, 1,   0, 0, 0, 0, 0, 16'h0001, 1, 0, 8, 0, 0, 0);
    tbl[24] = mk(1, 2,   0, 0, 0, 0, 0, 16'h0012, 2, 0, 8, 0, 0, 0);
    tbl[25] = mk(1, 7,   1, 0, 0, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[26] = mk(1, 1,   0, 0, 0, 0, 0, 16'h0001, 1, 0, 8, 0, 0, 0);
    tbl[27] = mk(1, 2,   0, 0, 0, 0, 0, 16'h0012, 2, 0, 8, 0, 0, 0);
    tbl[28] = mk(1, 3,   0, 0, 0, 0, 0, 16'h0123, 3, 0, 8, 0, 0, 0);
    tbl[29] = mk(1, 4,   0, 0, 0, 0, 0, 16'h1234, 4, 0, 8, 0, 0, 0);
    tbl[30] = mk(0, 0,   1, 1, 0, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[31] = mk(0, 0,   0, 0, 0, 0, 0, 16'h0000, 0, 0, 8, 0, 0, 0);
    tbl[32] = mk(1, 9,   0, 0, 0, 0, 0, 16'h0009, 1, 0, 8, 0, 0, 0);
    tbl[33] = mk(1, 8,   0, 0, 0, 0, 0, 16'h0098, 2, 0, 8, 0, 0, 0);
    tbl[34] = mk(1, 7,   0, 0, 0, 0, 0, 16'h0987, 3, 0, 8, 0, 0, 0);
    tbl[35] = mk(1, 6,   0, 0, 0, 0, 0, 16'h9876, 4, 0, 8, 0, 0, 0);
    tbl[36] = mk(0, 0,   0, 1, 0, 0, 0, 16'h9876, 4, 1, 8, 0, 0, 0);
    tbl[37] = mk(0, 0,   0, 0, 0, 1, 0, 16'h9876, 4, 0, 8, 0, 0, 0);
    tbl[38] = mk(0, 0,   0, 0, 0, 0, 3, 16'h0000, 0, 0, 7, 3, 0, 0);

    do_reset();
    chk("reset_b", 32'(obs(1)), 32'({16'h0, 3'd0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b0}));
    for (int i = 0; i < 39; i++) begin
      step(tbl[i].dv, tbl[i].d, tbl[i].clr, tbl[i].sub, tbl[i].ng, tbl[i].cor, tbl[i].nc);
      chk($sformatf("vec%0d", i), 32'(obs(0)),
          32'({tbl[i].mi, tbl[i].cnt, tbl[i].snd, tbl[i].tries, tbl[i].score, tbl[i].win, tbl[i].lose}));
    end

    // Two wrong guesses on the MAX_TRIES=2 instance run it out of tries.
    do_reset();
    for (int g = 0; g < 2; g++) begin
      for (int d = 1; d <= 4; d++) step(1, 4'(d), 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      chk("lose_send", 32'(send_b), 32'd1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, (g == 0) ? 4'd2 : 4'd1);
      chk($sformatf("lose_tries%0d", g), 32'(tries_b), (g == 0) ? 32'd1 : 32'd0);
      chk($sformatf("lose_flag%0d", g), 32'(lose_b), (g == 0) ? 32'd0 : 32'd1);
      chk($sformatf("lose_score%0d", g), 32'(score_b), (g == 0) ? 32'd2 : 32'd1);
    end
    step(1, 3, 0, 0, 0, 0, 0);
    chk("lose_dig_cnt", 32'(cnt_b), 32'd4);
    chk("lose_dig_val", 32'(mi_b), 32'h1234);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("lose_sub", 32'({send_b, lose_b}), 32'b01);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("newgame", 32'({tries_b, lose_b, cnt_b, score_b}), 32'({4'd2, 1'b0, 3'd0, 4'd0}));

    // Reset asserted mid-SEND must drop send without waiting for a clock edge.
    do_reset();
    for (int d = 1; d <= 4; d++) step(1, 4'(d), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("rst_send_hi", 32'(send_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_send_lo", 32'(send_a), 32'd0);
    chk("rst_tries", 32'(tries_a), 32'd8);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 5, 0, 0, 0, 0, 0);
    chk("rst_resume", 32'(obs(0)), 32'({16'h0005, 3'd1, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0}));

    // Random traffic against the model on both instances.
    do_reset();
    m_reset(0);
    m_reset(1);
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 11)), $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            4'($urandom_range(0, 4)));
      m_step(0);
      m_step(1);
      @(posedge clk);
      #1;
      chk($sformatf("rand_a%0d", n), 32'(obs(0)), 32'(m_exp(0)));
      chk($sformatf("rand_b%0d", n), 32'(obs(1)), 32'(m_exp(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
